// File: rtl/lsu_bridge.sv
// Load/store bridge: turns one core request (addr from ROA, data from ROD) into a single
// valid/ready bus transaction and returns extended load data or an error.
module lsu_bridge #(
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [1:0]               req_size_i,
  input  logic                     req_signed_i,
  input  logic [ADDRESS_WIDTH-1:0] req_addr_i,
  input  logic [WORD_WIDTH-1:0]    req_wdata_i,
  output logic                     rsp_valid_o,
  output logic [WORD_WIDTH-1:0]    rsp_rdata_o,
  output logic                     rsp_err_o,
  output logic                     bus_valid_o,
  input  logic                     bus_ready_i,
  output logic                     bus_we_o,
  output logic [ADDRESS_WIDTH-1:0] bus_addr_o,
  output logic [3:0]               bus_be_o,
  output logic [WORD_WIDTH-1:0]    bus_wdata_o,
  input  logic                     bus_rvalid_i,
  input  logic [WORD_WIDTH-1:0]    bus_rdata_i,
  input  logic                     bus_err_i
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [1:0]                 size_q, size_d, off_q, off_d;
  logic                       sgn_q, sgn_d, we_q, we_d;

  logic                       req_ready_d, rsp_valid_d, rsp_err_d;
  logic [WORD_WIDTH-1:0]      rsp_rdata_d;
  logic                       bus_valid_d, bus_we_d;
  logic [ADDRESS_WIDTH-1:0]   bus_addr_d;
  logic [3:0]                 bus_be_d;
  logic [WORD_WIDTH-1:0]      bus_wdata_d;

  logic                       misalign;
  logic [3:0]                 be_lanes;
  logic [WORD_WIDTH-1:0]      wdata_lanes;
  logic [WORD_WIDTH-1:0]      rdata_shift;
  logic [WORD_WIDTH-1:0]      load_data;

  // Request decode: alignment check, byte enables and lane-replicated store data
  always_comb begin
    misalign = (req_size_i == 2'b11)
            || ((req_size_i == 2'b01) && req_addr_i[0])
            || ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00));
    case (req_size_i)
      2'b00:   begin be_lanes = 4'b0001 << req_addr_i[1:0]; wdata_lanes = {4{req_wdata_i[7:0]}};  end
      2'b01:   begin be_lanes = 4'b0011 << req_addr_i[1:0]; wdata_lanes = {2{req_wdata_i[15:0]}}; end
      default: begin be_lanes = 4'b1111;                    wdata_lanes = req_wdata_i;            end
    endcase
  end

  // Load extract from the latched offset/size; word loads pass through unextended
  always_comb begin
    rdata_shift = bus_rdata_i >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_data = {{24{sgn_q & rdata_shift[7]}},  rdata_shift[7:0]};
      2'b01:   load_data = {{16{sgn_q & rdata_shift[15]}}, rdata_shift[15:0]};
      default: load_data = rdata_shift;
    endcase
  end

  // Next-state and next-output logic; every output is registered from these
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    off_d       = off_q;
    sgn_d       = sgn_q;
    we_d        = we_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    bus_valid_d = bus_valid_o;
    bus_we_d    = bus_we_o;
    bus_addr_d  = bus_addr_o;
    bus_be_d    = bus_be_o;
    bus_wdata_d = bus_wdata_o;

    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid_i && req_ready_o) begin
          size_d      = req_size_i;
          off_d       = req_addr_i[1:0];
          sgn_d       = req_signed_i;
          we_d        = req_we_i;
          req_ready_d = 1'b0;
          if (misalign) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = S_ISSUE;
            bus_valid_d = 1'b1;
            bus_we_d    = req_we_i;
            bus_addr_d  = {req_addr_i[ADDRESS_WIDTH-1:2], 2'b00};
            bus_be_d    = be_lanes;
            bus_wdata_d = wdata_lanes;
          end
        end
      end
      S_ISSUE: begin
        if (bus_ready_i) begin
          state_d     = S_WAIT;
          cnt_d       = '0;
          bus_valid_d = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = '0;
          bus_be_d    = '0;
          bus_wdata_d = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_rvalid_i) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus_err_i;
          rsp_rdata_d = (bus_err_i || we_q) ? '0 : load_data;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      S_RESP: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      size_q      <= '0;
      off_q       <= '0;
      sgn_q       <= 1'b0;
      we_q        <= 1'b0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
      bus_valid_o <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_be_o    <= '0;
      bus_wdata_o <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      off_q       <= off_d;
      sgn_q       <= sgn_d;
      we_q        <= we_d;
      req_ready_o <= req_ready_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_err_o   <= rsp_err_d;
      rsp_rdata_o <= rsp_rdata_d;
      bus_valid_o <= bus_valid_d;
      bus_we_o    <= bus_we_d;
      bus_addr_o  <= bus_addr_d;
      bus_be_o    <= bus_be_d;
      bus_wdata_o <= bus_wdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_bridge.sv
// Directed bench for lsu_bridge: expected responses are queued at request time and
// popped when rsp_valid_o fires; bus side is driven step by step.
module tb_lsu_bridge;

  logic        clk_i = 1'b0;
  logic        arst_i;
  logic        req_valid_i, req_we_i, req_signed_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        req_ready_o, rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        bus_valid_o, bus_ready_i, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_rvalid_i, bus_err_i;
  logic [31:0] bus_rdata_i;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int unsigned t_acc;
  } exp_t;

  exp_t        sb[$];
  int unsigned pcnt = 0;
  int          total = 0;
  int          bad = 0;

  lsu_bridge #(.WORD_WIDTH(32), .ADDRESS_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_signed_i(req_signed_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .bus_valid_o(bus_valid_o), .bus_ready_i(bus_ready_i), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) pcnt <= pcnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".req_ready"}, 32'(req_ready_o), 32'd1);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid_o), 32'd0);
    chk({tag, ".rsp_err"},   32'(rsp_err_o),   32'd0);
    chk({tag, ".rsp_rdata"}, rsp_rdata_o,      32'd0);
    chk({tag, ".bus_valid"}, 32'(bus_valid_o), 32'd0);
    chk({tag, ".bus_we"},    32'(bus_we_o),    32'd0);
    chk({tag, ".bus_addr"},  bus_addr_o,       32'd0);
    chk({tag, ".bus_be"},    32'(bus_be_o),    32'd0);
    chk({tag, ".bus_wdata"}, bus_wdata_o,      32'd0);
  endtask

  // Present a request for one cycle; returns at the negedge after acceptance.
  task automatic send(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic eerr, input logic [31:0] erd, input bit push);
    exp_t e;
    chk("req_ready_before_send", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_signed_i = sgn;
    req_addr_i = addr; req_wdata_i = wdata;
    e.err = eerr; e.rdata = erd; e.t_acc = pcnt;
    if (push) sb.push_back(e);
    @(negedge clk_i);
    req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00; req_signed_i = 1'b0;
    req_addr_i = 32'h0; req_wdata_i = 32'h0;
  endtask

  task automatic bus_cmd(input string tag, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input bit chk_wd, input logic [31:0] wd);
    chk({tag, ".bus_valid"}, 32'(bus_valid_o), 32'd1);
    chk({tag, ".bus_we"},    32'(bus_we_o),    32'(we));
    chk({tag, ".bus_addr"},  bus_addr_o,       addr);
    chk({tag, ".bus_be"},    32'(bus_be_o),    32'(be));
    if (chk_wd) chk({tag, ".bus_wdata"}, bus_wdata_o, wd);
  endtask

  task automatic bus_accept();
    bus_ready_i = 1'b1;
    @(negedge clk_i);
    bus_ready_i = 1'b0;
  endtask

  task automatic bus_resp(input logic [31:0] rd, input logic err);
    bus_rvalid_i = 1'b1; bus_rdata_i = rd; bus_err_i = err;
    @(negedge clk_i);
    bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0; bus_err_i = 1'b0;
  endtask

  // Wait (bounded) for the response pulse, compare against the queue head, then
  // confirm the pulse lasts one cycle and the bridge is ready again.
  task automatic expect_rsp(input string tag, input int unsigned lat);
    bit   found = 0;
    exp_t e;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid_o) begin found = 1; break; end
      @(negedge clk_i);
    end
    total++;
    assert (found) else begin
      bad++;
      $error("FAIL %s.rsp_timeout: observed=no_rsp expected=rsp_valid", tag);
    end
    if (found && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, ".rsp_err"},   32'(rsp_err_o), 32'(e.err));
      chk({tag, ".rsp_rdata"}, rsp_rdata_o,    e.rdata);
      chk({tag, ".latency"},   pcnt - e.t_acc, lat);
      @(negedge clk_i);
      chk({tag, ".rsp_pulse"}, 32'(rsp_valid_o), 32'd0);
      chk({tag, ".b2b_ready"}, 32'(req_ready_o), 32'd1);
    end
  endtask

  initial begin
    arst_i = 1'b0;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00; req_signed_i = 1'b0;
    req_addr_i = 32'h0; req_wdata_i = 32'h0;
    bus_ready_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0; bus_err_i = 1'b0;

    // Reset values
    repeat (2) @(negedge clk_i);
    chk_quiet("reset");
    arst_i = 1'b1;
    @(negedge clk_i);
    chk_quiet("post_reset");

    // Signed byte load from the top lane
    send(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1'b0, 32'hFFFF_FF80, 1);
    bus_cmd("byte_ld", 1'b0, 32'h100, 4'b1000, 0, 32'h0);
    bus_accept();
    bus_resp(32'h80FF_1234, 1'b0);
    expect_rsp("byte_ld", 3);

    // Half store to upper half, data replicated
    send(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF, 1'b0, 32'h0, 1);
    bus_cmd("half_st", 1'b1, 32'h20, 4'b1100, 1, 32'hBEEF_BEEF);
    bus_accept();
    bus_resp(32'h1234_5678, 1'b0);
    expect_rsp("half_st", 3);

    // Misaligned word, misaligned half, reserved size: immediate error, no bus cycle
    send(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b1, 32'h0, 1);
    chk("mis_word.bus_valid", 32'(bus_valid_o), 32'd0);
    expect_rsp("mis_word", 1);
    send(1'b0, 2'b01, 1'b1, 32'h41, 32'h0, 1'b1, 32'h0, 1);
    chk("mis_half.bus_valid", 32'(bus_valid_o), 32'd0);
    expect_rsp("mis_half", 1);
    send(1'b1, 2'b11, 1'b0, 32'h40, 32'hFFFF_FFFF, 1'b1, 32'h0, 1);
    chk("rsvd_size.bus_valid", 32'(bus_valid_o), 32'd0);
    expect_rsp("rsvd_size", 1);

    // Timeout: WAIT entered at accept+2, error response 4 cycles later
    send(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, 32'h0, 1);
    bus_cmd("timeout", 1'b0, 32'h40, 4'b1111, 0, 32'h0);
    bus_accept();
    expect_rsp("timeout", 6);

    // Stalled command stays stable; bus error on a store
    send(1'b1, 2'b00, 1'b0, 32'h81, 32'h1234_565A, 1'b1, 32'h0, 1);
    for (int i = 0; i < 3; i++) begin
      bus_cmd("stall_st", 1'b1, 32'h80, 4'b0010, 1, 32'h5A5A_5A5A);
      @(negedge clk_i);
    end
    bus_cmd("stall_st_last", 1'b1, 32'h80, 4'b0010, 1, 32'h5A5A_5A5A);
    bus_accept();
    bus_resp(32'hFFFF_FFFF, 1'b1);
    expect_rsp("stall_st", 6);

    // Bus error on a load zeroes the data
    send(1'b0, 2'b10, 1'b0, 32'h90, 32'h0, 1'b1, 32'h0, 1);
    bus_accept();
    bus_resp(32'hDEAD_BEEF, 1'b0 | 1'b1);
    expect_rsp("ld_buserr", 3);

    // rvalid during ISSUE is ignored; the real response comes later
    send(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 1'b0, 32'h1122_3344, 1);
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0000_0BAD; bus_err_i = 1'b1;
    bus_accept();
    bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0; bus_err_i = 1'b0;
    @(negedge clk_i);
    bus_resp(32'h1122_3344, 1'b0);
    expect_rsp("early_rvalid", 4);

    // Extension variants
    send(1'b0, 2'b01, 1'b1, 32'h02, 32'h0, 1'b0, 32'hFFFF_8001, 1);
    bus_accept();
    bus_resp(32'h8001_0000, 1'b0);
    expect_rsp("half_ld_s", 3);
    send(1'b0, 2'b01, 1'b0, 32'h02, 32'h0, 1'b0, 32'h0000_8001, 1);
    bus_accept();
    bus_resp(32'h8001_0000, 1'b0);
    expect_rsp("half_ld_u", 3);
    send(1'b0, 2'b00, 1'b0, 32'h01, 32'h0, 1'b0, 32'h0000_009A, 1);
    bus_cmd("byte_ld_u", 1'b0, 32'h0, 4'b0010, 0, 32'h0);
    bus_accept();
    bus_resp(32'h0000_9A00, 1'b0);
    expect_rsp("byte_ld_u", 3);
    send(1'b0, 2'b10, 1'b1, 32'h00, 32'h0, 1'b0, 32'h8765_4321, 1);
    bus_accept();
    bus_resp(32'h8765_4321, 1'b0);
    expect_rsp("word_ld", 3);

    // Reset in WAIT drops the transaction silently
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 0);
    bus_accept();
    arst_i = 1'b0;
    #1;
    chk_quiet("mid_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("mid_reset.no_rsp", 32'(rsp_valid_o), 32'd0);
    end
    arst_i = 1'b1;
    @(negedge clk_i);
    chk_quiet("after_mid_reset");
    send(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 32'h0000_8001, 1);
    bus_cmd("post_rst_ld", 1'b0, 32'h10, 4'b1100, 0, 32'h0);
    bus_accept();
    bus_resp(32'h8001_0000, 1'b0);
    expect_rsp("post_rst_ld", 3);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
